// File: rtl/alu_shift_datapath_pkg.sv
// Shared types for the execute datapath: ALU opcodes, shift kinds and the NZCV flag group.
package alu_shift_datapath_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_EOR = 4'd1,
        OP_SUB = 4'd2,
        OP_RSB = 4'd3,
        OP_ADD = 4'd4,
        OP_ADC = 4'd5,
        OP_SBC = 4'd6,
        OP_RSC = 4'd7,
        OP_TST = 4'd8,
        OP_TEQ = 4'd9,
        OP_CMP = 4'd10,
        OP_CMN = 4'd11,
        OP_ORR = 4'd12,
        OP_MOV = 4'd13,
        OP_BIC = 4'd14,
        OP_MVN = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_type_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_if.sv
// ALU-side signal bundle: operands, opcode, flags and the shifter carry feeding logical ops.
interface alu_if;
    import alu_shift_datapath_pkg::*;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    alu_op_t           alu_op;
    flags_t            flags_in;
    logic              shifter_carry;
    logic [DATA_W-1:0] result;
    flags_t            flags_out;

    modport alu (
        input  op_a, op_b, alu_op, flags_in, shifter_carry,
        output result, flags_out
    );
endinterface

// File: rtl/alu_shift_datapath_barrel_shifter.sv
// Barrel shifter with ARM immediate/register amount semantics and the register-shift amount latch.
module barrel_shifter
    import alu_shift_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] r_in,
    input  logic [1:0]        shift_type,
    input  logic [4:0]        shift_amount,
    input  logic              shift_latch_amt,
    input  logic              shift_use_latch,
    input  logic              shift_use_rxx,
    input  logic              carry_in,
    output logic [DATA_W-1:0] shift_out,
    output logic              shift_carry
);

    logic [7:0]  amt_latch;
    logic [7:0]  amt;
    logic        rrx;
    logic [4:0]  amt_lo;
    logic [4:0]  amt_neg;
    logic [4:0]  amt_dec;
    shift_type_t sh;

    always_ff @(posedge clk) begin
        if (!reset)
            amt_latch <= 8'd0;
        else if (shift_latch_amt)
            amt_latch <= r_in[7:0];
    end

    assign sh = shift_type_t'(shift_type);

    // Immediate encodings of #0 are folded into register-mode amounts so one core handles both.
    always_comb begin
        amt = 8'd0;
        rrx = 1'b0;
        if (shift_use_latch) begin
            amt = amt_latch;
        end else begin
            amt = {3'b000, shift_amount};
            if (shift_amount == 5'd0) begin
                case (sh)
                    SH_LSR, SH_ASR: amt = 8'd32;
                    SH_ROR:         rrx = shift_use_rxx;
                    default:        amt = 8'd0;
                endcase
            end
        end
    end

    assign amt_lo  = amt[4:0];
    assign amt_neg = 5'd0 - amt_lo;
    assign amt_dec = amt_lo - 5'd1;

    always_comb begin
        shift_out   = r_in;
        shift_carry = carry_in;
        if (rrx) begin
            shift_out   = {carry_in, r_in[DATA_W-1:1]};
            shift_carry = r_in[0];
        end else if (amt != 8'd0) begin
            case (sh)
                SH_LSL: begin
                    if (amt < 8'd32) begin
                        shift_out   = r_in << amt_lo;
                        shift_carry = r_in[amt_neg];
                    end else begin
                        shift_out   = '0;
                        shift_carry = (amt == 8'd32) ? r_in[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amt < 8'd32) begin
                        shift_out   = r_in >> amt_lo;
                        shift_carry = r_in[amt_dec];
                    end else begin
                        shift_out   = '0;
                        shift_carry = (amt == 8'd32) ? r_in[DATA_W-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (amt < 8'd32) begin
                        shift_out   = $signed(r_in) >>> amt_lo;
                        shift_carry = r_in[amt_dec];
                    end else begin
                        shift_out   = {DATA_W{r_in[DATA_W-1]}};
                        shift_carry = r_in[DATA_W-1];
                    end
                end
                default: begin
                    if (amt_lo == 5'd0) begin
                        shift_out   = r_in;
                        shift_carry = r_in[DATA_W-1];
                    end else begin
                        shift_out   = (r_in >> amt_lo) | (r_in << amt_neg);
                        shift_carry = r_in[amt_dec];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_shift_datapath.sv
// Execute datapath top: shifter into operand B, operand-B/carry latches, and the 16-op ALU.
module alu_shift_datapath
    import alu_shift_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] r_in,
    input  logic [3:0]        alu_op,
    input  logic [3:0]        flags_in,
    input  logic              use_op_b_latch,
    input  logic              disable_op_b,
    input  logic              latch_op_b,
    input  logic [1:0]        shift_type,
    input  logic [4:0]        shift_amount,
    input  logic              shift_latch_amt,
    input  logic              shift_use_latch,
    input  logic              shift_use_rxx,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags_out
);

    logic [DATA_W-1:0] shift_out;
    logic              shift_carry;
    logic [DATA_W-1:0] op_b_latch;
    logic              carry_latch;
    logic [DATA_W-1:0] alu_result;
    flags_t            alu_flags;

    alu_if alu_bus ();

    barrel_shifter u_shifter (
        .clk             (clk),
        .reset           (reset),
        .r_in            (r_in),
        .shift_type      (shift_type),
        .shift_amount    (shift_amount),
        .shift_latch_amt (shift_latch_amt),
        .shift_use_latch (shift_use_latch),
        .shift_use_rxx   (shift_use_rxx),
        .carry_in        (carry_in),
        .shift_out       (shift_out),
        .shift_carry     (shift_carry)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_b_latch  <= '0;
            carry_latch <= 1'b0;
        end else if (latch_op_b) begin
            op_b_latch  <= shift_out;
            carry_latch <= shift_carry;
        end
    end

    assign alu_bus.op_a          = op_a;
    assign alu_bus.op_b          = disable_op_b   ? '0 :
                                   use_op_b_latch ? op_b_latch : shift_out;
    assign alu_bus.alu_op        = alu_op_t'(alu_op);
    assign alu_bus.flags_in      = flags_t'(flags_in);
    assign alu_bus.shifter_carry = use_op_b_latch ? carry_latch : shift_carry;

    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic              add_cin;
    logic              is_arith;
    logic [DATA_W:0]   sum;

    // Subtract forms are A + ~B + cin so the adder carry-out is directly NOT borrow.
    always_comb begin
        add_x    = alu_bus.op_a;
        add_y    = alu_bus.op_b;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (alu_bus.alu_op)
            OP_SUB, OP_CMP: begin add_y = ~alu_bus.op_b; add_cin = 1'b1; end
            OP_RSB: begin add_x = alu_bus.op_b; add_y = ~alu_bus.op_a; add_cin = 1'b1; end
            OP_ADD, OP_CMN: add_cin = 1'b0;
            OP_ADC: add_cin = alu_bus.flags_in.c;
            OP_SBC: begin add_y = ~alu_bus.op_b; add_cin = alu_bus.flags_in.c; end
            OP_RSC: begin
                add_x   = alu_bus.op_b;
                add_y   = ~alu_bus.op_a;
                add_cin = alu_bus.flags_in.c;
            end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};

    always_comb begin
        alu_result  = sum[DATA_W-1:0];
        alu_flags.c = sum[DATA_W];
        alu_flags.v = (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                      (sum[DATA_W-1] != add_x[DATA_W-1]);
        if (!is_arith) begin
            alu_flags.c = alu_bus.shifter_carry;
            alu_flags.v = alu_bus.flags_in.v;
            case (alu_bus.alu_op)
                OP_AND, OP_TST: alu_result = alu_bus.op_a & alu_bus.op_b;
                OP_EOR, OP_TEQ: alu_result = alu_bus.op_a ^ alu_bus.op_b;
                OP_ORR:         alu_result = alu_bus.op_a | alu_bus.op_b;
                OP_MOV:         alu_result = alu_bus.op_b;
                OP_BIC:         alu_result = alu_bus.op_a & ~alu_bus.op_b;
                default:        alu_result = ~alu_bus.op_b;
            endcase
        end
        alu_flags.n = alu_result[DATA_W-1];
        alu_flags.z = (alu_result == '0);
    end

    assign alu_bus.result    = alu_result;
    assign alu_bus.flags_out = alu_flags;

    assign result    = alu_bus.result;
    assign flags_out = alu_bus.flags_out;

endmodule

// File: tb/tb_alu_shift_datapath.sv
// Directed bench for alu_shift_datapath with hand-computed results and NZCV flags.
module tb_alu_shift_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_a;
    logic [31:0] r_in;
    logic [3:0]  alu_op;
    logic [3:0]  flags_in;
    logic        use_op_b_latch;
    logic        disable_op_b;
    logic        latch_op_b;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amount;
    logic        shift_latch_amt;
    logic        shift_use_latch;
    logic        shift_use_rxx;
    logic        carry_in;
    logic [31:0] result;
    logic [3:0]  flags_out;

    int checks   = 0;
    int failures = 0;

    alu_shift_datapath dut (
        .clk             (clk),
        .reset           (reset),
        .op_a            (op_a),
        .r_in            (r_in),
        .alu_op          (alu_op),
        .flags_in        (flags_in),
        .use_op_b_latch  (use_op_b_latch),
        .disable_op_b    (disable_op_b),
        .latch_op_b      (latch_op_b),
        .shift_type      (shift_type),
        .shift_amount    (shift_amount),
        .shift_latch_amt (shift_latch_amt),
        .shift_use_latch (shift_use_latch),
        .shift_use_rxx   (shift_use_rxx),
        .carry_in        (carry_in),
        .result          (result),
        .flags_out       (flags_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; op_a = '0; r_in = '0; alu_op = 4'd13; flags_in = 4'b0000;
        use_op_b_latch = 1'b0; disable_op_b = 1'b0; latch_op_b = 1'b0;
        shift_type = 2'd0; shift_amount = 5'd0; shift_latch_amt = 1'b0;
        shift_use_latch = 1'b0; shift_use_rxx = 1'b0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // reset state of op_b and carry latches
        r_in = 32'h1234; use_op_b_latch = 1'b1; alu_op = 4'd12; op_a = 0; #1;
        check("rst_opb_res", result, 32'h0);
        check("rst_opb_flg", {28'h0, flags_out}, 32'h4);
        // reset state of amount latch: register mode with amt 0 passes, C = carry_in
        use_op_b_latch = 1'b0; shift_use_latch = 1'b1; alu_op = 4'd13; r_in = 5; carry_in = 1; #1;
        check("rst_amt_res", result, 32'h5);
        check("rst_amt_flg", {28'h0, flags_out}, 32'h2);
        shift_use_latch = 1'b0; carry_in = 0;

        op_a = 5; r_in = 3; alu_op = 4'd4; #1;
        check("add_res", result, 32'h8);
        check("add_flg", {28'h0, flags_out}, 32'h0);

        op_a = 3; r_in = 5; alu_op = 4'd2; #1;
        check("sub_res", result, 32'hFFFF_FFFE);
        check("sub_flg", {28'h0, flags_out}, 32'h8);

        op_a = 5; r_in = 5; alu_op = 4'd10; #1;
        check("cmp_res", result, 32'h0);
        check("cmp_flg", {28'h0, flags_out}, 32'h6);

        op_a = 1; r_in = 3; alu_op = 4'd3; #1;
        check("rsb_res", result, 32'h2);
        check("rsb_flg", {28'h0, flags_out}, 32'h2);

        op_a = 5; r_in = 3; alu_op = 4'd6; flags_in = 4'b0000; #1;
        check("sbc_res", result, 32'h1);
        check("sbc_flg", {28'h0, flags_out}, 32'h2);

        op_a = 32'hFF; r_in = 32'h0F; alu_op = 4'd14; #1;
        check("bic_res", result, 32'hF0);
        r_in = 0; alu_op = 4'd15; #1;
        check("mvn_res", result, 32'hFFFF_FFFF);

        r_in = 32'h8000_0001; alu_op = 4'd13; shift_type = 2'd1; shift_amount = 0; #1;
        check("lsr0_res", result, 32'h0);
        check("lsr0_flg", {28'h0, flags_out}, 32'h6);

        shift_type = 2'd3; shift_use_rxx = 1; carry_in = 1; #1;
        check("rrx_res", result, 32'hC000_0000);
        check("rrx_flg", {28'h0, flags_out}, 32'hA);
        shift_use_rxx = 0; carry_in = 0;

        r_in = 32'h8000_0000; shift_type = 2'd2; shift_amount = 0; #1;
        check("asr0_res", result, 32'hFFFF_FFFF);
        check("asr0_flg", {28'h0, flags_out}, 32'hA);

        r_in = 32'hF0; shift_type = 2'd1; shift_amount = 4; carry_in = 1; #1;
        check("lsr4_res", result, 32'h0F);
        check("lsr4_flg", {28'h0, flags_out}, 32'h0);
        carry_in = 0;

        // register-shift amounts
        r_in = 32'h21; shift_latch_amt = 1; tick(); shift_latch_amt = 0;
        r_in = 1; shift_type = 2'd0; shift_use_latch = 1; #1;
        check("lsl33_res", result, 32'h0);
        check("lsl33_flg", {28'h0, flags_out}, 32'h4);

        shift_use_latch = 0; r_in = 32'h20; shift_latch_amt = 1; tick(); shift_latch_amt = 0;
        r_in = 1; shift_use_latch = 1; #1;
        check("lsl32_res", result, 32'h0);
        check("lsl32_flg", {28'h0, flags_out}, 32'h6);

        r_in = 32'h8000_0000; shift_type = 2'd3; #1;
        check("ror32_res", result, 32'h8000_0000);
        check("ror32_flg", {28'h0, flags_out}, 32'hA);

        shift_use_latch = 0; r_in = 0; shift_latch_amt = 1; tick(); shift_latch_amt = 0;
        r_in = 1; shift_type = 2'd0; shift_use_latch = 1; carry_in = 0; #1;
        check("amt0_res", result, 32'h1);
        check("amt0_flg", {28'h0, flags_out}, 32'h0);
        shift_use_latch = 0;

        op_a = 32'h7FFF_FFFF; r_in = 1; shift_amount = 0; alu_op = 4'd4; #1;
        check("addv_res", result, 32'h8000_0000);
        check("addv_flg", {28'h0, flags_out}, 32'h9);
        alu_op = 4'd5; flags_in = 4'b0010; #1;
        check("adc_res", result, 32'h8000_0001);
        check("adc_flg", {28'h0, flags_out}, 32'h9);
        flags_in = 4'b0000;

        // operand-B latch path
        r_in = 32'hAA; latch_op_b = 1; tick(); latch_op_b = 0;
        r_in = 32'h55; use_op_b_latch = 1; op_a = 0; alu_op = 4'd12; #1;
        check("opb_latch_res", result, 32'hAA);
        check("opb_latch_flg", {28'h0, flags_out}, 32'h0);
        disable_op_b = 1; op_a = 7; alu_op = 4'd4; #1;
        check("opb_dis_res", result, 32'h7);
        disable_op_b = 0;

        reset = 0; tick(); reset = 1;
        op_a = 0; alu_op = 4'd12; #1;
        check("opb_rst_res", result, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
